pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the 5-stage core. It collects hazard and memory-readiness events and drives the write-enable and flush strobes of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers; decode's `we` input is `id_ex_we` from this block. It also sequences an orderly halt (drain then stop), runs a data-memory timeout watchdog and keeps stall and flush performance counters.

## Interface
- `DRAIN_CYCLES`, default 3: bubble cycles issued after a halt request before stopping (legal range 1–15).
- `MEM_TIMEOUT`, default 255: maximum consecutive `dmem_busy` cycles tolerated (legal range 1–65535).
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `load_use_stall` in 1: load-use hazard from decode.
- `take_branch` in 1: branch/jump resolved taken in EX this cycle.
- `imem_valid` in 1: fetch data valid this cycle.
- `dmem_busy` in 1: data memory cannot complete this cycle.
- `halt_req` in 1: halt request (ecall/ebreak/debug).
- `resume` in 1: leave HALT.
- `pc_we`, `if_id_we`, `id_ex_we`, `ex_mem_we`, `mem_wb_we` out 1: register enables.
- `if_id_flush`, `id_ex_flush` out 1: insert a bubble. Flush has priority over enable in the target register.
- `halted` out 1: the FSM is in HALT.
- `err_timeout` out 1: sticky watchdog error.
- `stall_cycles` out 32: count of RUN cycles with `pc_we`=0.
- `flush_count` out 32: count of accepted taken branches.

## Operation
- FSM states and encodings: RUN=2'b00, DRAIN=2'b01, HALT=2'b10. 2'b11 is illegal and is forced to HALT.
- Strobes are combinational from state and inputs. Only state, counters and `err_timeout` are registered.
- RUN strobes, first matching rule wins:
  - `dmem_busy`: all five enables 0, both flushes 0. Full freeze.
  - `take_branch`: `pc_we`=1, `if_id_flush`=1, `id_ex_flush`=1, `if_id_we`=0, `ex_mem_we`=1, `mem_wb_we`=1. `flush_count` increments.
  - `load_use_stall`: `pc_we`=0, `if_id_we`=0, `id_ex_we`=0, `id_ex_flush`=1, `ex_mem_we`=1, `mem_wb_we`=1.
  - `!imem_valid`: `pc_we`=0, `if_id_flush`=1, all other enables 1.
  - Otherwise: all enables 1, both flushes 0.
- RUN to DRAIN: `halt_req`=1 while `dmem_busy`=0 and `take_branch`=0.
  - Strobes still follow the RUN rules that cycle.
  - The drain counter loads `DRAIN_CYCLES`.
- DRAIN:
  - Strobes: `pc_we`=0, `if_id_flush`=1, `id_ex_flush`=1, downstream enables 1.
  - `take_branch` and `halt_req` are ignored.
  - `dmem_busy` freezes everything and holds the drain counter.
  - The counter decrements on non-busy cycles. When it reaches 0, the FSM enters HALT.
- HALT:
  - All enables 0 and flushes 0; `halted`=1.
  - `resume`=1 returns to RUN next cycle, but only if `err_timeout`=0.
  - `halt_req` is ignored.
- Watchdog (RUN and DRAIN only):
  - A 16-bit wait counter increments each cycle `dmem_busy`=1 and clears when `dmem_busy`=0.
  - If `dmem_busy`=1 while the counter already equals `MEM_TIMEOUT`, the FSM goes to HALT and `err_timeout` sets.
  - `err_timeout` clears only on reset.
- `stall_cycles` counts RUN cycles with `pc_we`=0 and excludes DRAIN/HALT cycles. It and `flush_count` wrap modulo 2^32.

## Timing
- Reset (asynchronous, immediate):
  - state=RUN; `halted`=0, `err_timeout`=0; all counters 0.
  - Strobes then follow the RUN rules from the inputs, so with idle inputs and `imem_valid`=1 all enables read 1.
  - Reset during DRAIN or HALT aborts the sequence.
- Strobe latency is zero: same cycle as the causing input.
- State, `halted` and `err_timeout` change one edge after the triggering condition.
- A halt request completes in exactly `DRAIN_CYCLES`+1 edges when memory is not busy (RUN→DRAIN edge plus `DRAIN_CYCLES` drain edges).
- Timeout: `dmem_busy` held continuously from cycle 0 produces HALT and `err_timeout` at the edge ending cycle `MEM_TIMEOUT`, i.e. after `MEM_TIMEOUT`+1 busy cycles.
- Simultaneous events:
  - `take_branch` with `load_use_stall`: the branch wins.
  - `halt_req` with `take_branch`: the branch is accepted and the halt stays pending only if `halt_req` is still high next cycle.
  - `resume` with `err_timeout`=1: no effect.

## Test plan
- Reset with idle inputs and `imem_valid`=1 → all enables 1, flushes 0, counters 0, `halted`=0.
- `load_use_stall` for 1 cycle → that cycle `pc_we`=0, `if_id_we`=0, `id_ex_flush`=1, `ex_mem_we`=1; `stall_cycles`=1.
- `take_branch` together with `load_use_stall` → `pc_we`=1, `if_id_flush`=1, `id_ex_flush`=1; `flush_count`=1, `stall_cycles` unchanged.
- `halt_req` pulse, `DRAIN_CYCLES`=3 → 3 DRAIN cycles with `pc_we`=0 and both flushes 1, then `halted`=1; `resume` → RUN next edge.
- `dmem_busy` mid-DRAIN for 5 cycles → all enables 0 for those 5 cycles and the drain count is preserved; HALT arrives 5 cycles later than without the stall.
- `MEM_TIMEOUT`=4 with `dmem_busy` held → HALT and `err_timeout`=1 after 5 busy cycles; `resume` ignored; reset clears everything.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline stall/flush sequencer and the core.
// The slave side is the sequencer itself; the master side is the core/bench
// that raises hazard and memory events and consumes the register strobes.
interface pipeline_ctrl_if;
  // Events into the sequencer
  logic        load_use_stall;
  logic        take_branch;
  logic        imem_valid;
  logic        dmem_busy;
  logic        halt_req;
  logic        resume;
  // Pipeline register strobes
  logic        pc_we;
  logic        if_id_we;
  logic        id_ex_we;
  logic        ex_mem_we;
  logic        mem_wb_we;
  logic        if_id_flush;
  logic        id_ex_flush;
  // Status and performance counters
  logic        halted;
  logic        err_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  modport slave (
    input  load_use_stall, take_branch, imem_valid, dmem_busy, halt_req, resume,
    output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
    output if_id_flush, id_ex_flush,
    output halted, err_timeout, stall_cycles, flush_count
  );

  modport master (
    output load_use_stall, take_branch, imem_valid, dmem_busy, halt_req, resume,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
    input  if_id_flush, id_ex_flush,
    input  halted, err_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage core.
// Strobes are decoded combinationally from the registered state and the
// current events; state, drain/wait counters, the sticky timeout flag and the
// performance counters are the only registered elements.
module pipeline_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            reset,
  pipeline_ctrl_if.slave  bus
);

  localparam logic [1:0]  ST_RUN     = 2'b00;
  localparam logic [1:0]  ST_DRAIN   = 2'b01;
  localparam logic [1:0]  ST_HALT    = 2'b10;
  localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN_CYCLES);
  localparam logic [15:0] WAIT_LIMIT = 16'(MEM_TIMEOUT);

  logic [1:0]  state_q,  state_d;
  logic [3:0]  drain_q,  drain_d;
  logic [15:0] wait_q,   wait_d;
  logic        err_q,    err_d;
  logic [31:0] stall_q,  stall_d;
  logic [31:0] flush_q,  flush_d;

  logic        pc_we_s;
  logic        if_id_we_s;
  logic        id_ex_we_s;
  logic        ex_mem_we_s;
  logic        mem_wb_we_s;
  logic        if_id_flush_s;
  logic        id_ex_flush_s;
  logic        wd_expire_s;

  // Watchdog trips when memory is still busy after the counter hit the limit
  always_comb begin
    wd_expire_s = 1'b0;
    if (bus.dmem_busy && (wait_q == WAIT_LIMIT)) begin
      wd_expire_s = 1'b1;
    end else begin
      wd_expire_s = 1'b0;
    end
  end

  // Strobe decode from state and same-cycle events (zero latency)
  always_comb begin
    pc_we_s       = 1'b0;
    if_id_we_s    = 1'b0;
    id_ex_we_s    = 1'b0;
    ex_mem_we_s   = 1'b0;
    mem_wb_we_s   = 1'b0;
    if_id_flush_s = 1'b0;
    id_ex_flush_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.dmem_busy) begin
          // Full freeze: every register holds its contents
          pc_we_s = 1'b0;
        end else if (bus.take_branch) begin
          // Redirect fetch and squash the two wrong-path instructions
          pc_we_s       = 1'b1;
          if_id_flush_s = 1'b1;
          id_ex_flush_s = 1'b1;
          id_ex_we_s    = 1'b1;
          ex_mem_we_s   = 1'b1;
          mem_wb_we_s   = 1'b1;
        end else if (bus.load_use_stall) begin
          // Hold fetch/decode, push a bubble into EX
          id_ex_flush_s = 1'b1;
          ex_mem_we_s   = 1'b1;
          mem_wb_we_s   = 1'b1;
        end else if (!bus.imem_valid) begin
          // No instruction fetched: keep PC, feed a bubble into decode
          if_id_flush_s = 1'b1;
          if_id_we_s    = 1'b1;
          id_ex_we_s    = 1'b1;
          ex_mem_we_s   = 1'b1;
          mem_wb_we_s   = 1'b1;
        end else begin
          pc_we_s     = 1'b1;
          if_id_we_s  = 1'b1;
          id_ex_we_s  = 1'b1;
          ex_mem_we_s = 1'b1;
          mem_wb_we_s = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (bus.dmem_busy) begin
          // Memory stall freezes the drain as well
          pc_we_s = 1'b0;
        end else begin
          // Stop fetching, keep bubbles flowing, let older work retire
          if_id_flush_s = 1'b1;
          id_ex_flush_s = 1'b1;
          if_id_we_s    = 1'b1;
          id_ex_we_s    = 1'b1;
          ex_mem_we_s   = 1'b1;
          mem_wb_we_s   = 1'b1;
        end
      end
      default: begin
        // HALT and the illegal encoding: everything held
        pc_we_s = 1'b0;
      end
    endcase
  end

  // Next-state, watchdog and counter update logic
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    wait_d  = wait_q;
    err_d   = err_q;
    stall_d = stall_q;
    flush_d = flush_q;
    case (state_q)
      ST_RUN: begin
        if (!pc_we_s) begin
          stall_d = stall_q + 32'd1;
        end else begin
          stall_d = stall_q;
        end
        if (bus.dmem_busy) begin
          if (wd_expire_s) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
            wait_d  = 16'd0;
          end else begin
            wait_d = wait_q + 16'd1;
          end
        end else begin
          wait_d = 16'd0;
          if (bus.take_branch) begin
            // Branch wins over a simultaneous halt request
            flush_d = flush_q + 32'd1;
          end else if (bus.halt_req) begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_LOAD;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_DRAIN: begin
        if (bus.dmem_busy) begin
          if (wd_expire_s) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
            wait_d  = 16'd0;
          end else begin
            wait_d = wait_q + 16'd1;
          end
        end else begin
          wait_d = 16'd0;
          if (drain_q <= 4'd1) begin
            state_d = ST_HALT;
            drain_d = 4'd0;
          end else begin
            drain_d = drain_q - 4'd1;
          end
        end
      end
      ST_HALT: begin
        wait_d = 16'd0;
        if (bus.resume && !err_q) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        // Illegal encoding recovers into HALT
        state_d = ST_HALT;
        wait_d  = 16'd0;
      end
    endcase
  end

  // State and counter registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      drain_q <= 4'd0;
      wait_q  <= 16'd0;
      err_q   <= 1'b0;
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pc_we        = pc_we_s;
  assign bus.if_id_we     = if_id_we_s;
  assign bus.id_ex_we     = id_ex_we_s;
  assign bus.ex_mem_we    = ex_mem_we_s;
  assign bus.mem_wb_we    = mem_wb_we_s;
  assign bus.if_id_flush  = if_id_flush_s;
  assign bus.id_ex_flush  = id_ex_flush_s;
  assign bus.halted       = (state_q == ST_HALT) || (state_q == 2'b11);
  assign bus.err_timeout  = err_q;
  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: one instance with the default watchdog for
// the strobe and drain sequences, one with a short watchdog for timeout.
module tb_pipeline_ctrl;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  pipeline_ctrl_if ifa ();
  pipeline_ctrl_if ifb ();

  pipeline_ctrl #(.DRAIN_CYCLES(3), .MEM_TIMEOUT(255)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  pipeline_ctrl #(.DRAIN_CYCLES(3), .MEM_TIMEOUT(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and step past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ifa.load_use_stall = 1'b0;
    ifa.take_branch    = 1'b0;
    ifa.imem_valid     = 1'b1;
    ifa.dmem_busy      = 1'b0;
    ifa.halt_req       = 1'b0;
    ifa.resume         = 1'b0;
  endtask

  // Pack enables {pc,if_id,id_ex,ex_mem,mem_wb} and flushes {if_id,id_ex}
  function automatic logic [31:0] strobes_a();
    return {25'd0, ifa.pc_we, ifa.if_id_we, ifa.id_ex_we, ifa.ex_mem_we,
            ifa.mem_wb_we, ifa.if_id_flush, ifa.id_ex_flush};
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    idle_a();
    ifb.load_use_stall = 1'b0;
    ifb.take_branch    = 1'b0;
    ifb.imem_valid     = 1'b1;
    ifb.dmem_busy      = 1'b0;
    ifb.halt_req       = 1'b0;
    ifb.resume         = 1'b0;
    reset = 1'b1;
    #12;
    chk("reset_strobes", strobes_a(), 32'b11111_00);
    chk("reset_stall",   ifa.stall_cycles, 32'd0);
    chk("reset_flush",   ifa.flush_count, 32'd0);
    chk("reset_halted",  {31'd0, ifa.halted}, 32'd0);
    chk("reset_err",     {31'd0, ifa.err_timeout}, 32'd0);
    reset = 1'b0;
    tick();

    // Load-use stall for one cycle
    ifa.load_use_stall = 1'b1;
    #1;
    chk("loaduse_strobes", strobes_a(), 32'b00011_01);
    tick();
    idle_a();
    #1;
    chk("loaduse_stallcnt", ifa.stall_cycles, 32'd1);
    chk("after_loaduse",    strobes_a(), 32'b11111_00);

    // Branch together with load-use: branch wins
    ifa.take_branch    = 1'b1;
    ifa.load_use_stall = 1'b1;
    #1;
    chk("branch_strobes", strobes_a(), 32'b10111_11);
    tick();
    idle_a();
    #1;
    chk("branch_flushcnt", ifa.flush_count, 32'd1);
    chk("branch_stallcnt", ifa.stall_cycles, 32'd1);

    // Fetch not valid
    ifa.imem_valid = 1'b0;
    #1;
    chk("imem_strobes", strobes_a(), 32'b01111_10);
    tick();
    idle_a();
    #1;
    chk("imem_stallcnt", ifa.stall_cycles, 32'd2);

    // One busy cycle in RUN
    ifa.dmem_busy = 1'b1;
    #1;
    chk("busy_run_strobes", strobes_a(), 32'b00000_00);
    tick();
    idle_a();
    #1;
    chk("busy_run_stallcnt", ifa.stall_cycles, 32'd3);

    // Halt with branch: branch accepted, halt dropped
    ifa.halt_req    = 1'b1;
    ifa.take_branch = 1'b1;
    #1;
    chk("halt_br_strobes", strobes_a(), 32'b10111_11);
    tick();
    idle_a();
    #1;
    chk("halt_br_still_run", strobes_a(), 32'b11111_00);
    chk("halt_br_flushcnt",  ifa.flush_count, 32'd2);

    // Halt pulse: three drain cycles then HALT
    ifa.halt_req = 1'b1;
    #1;
    chk("halt_req_cycle", strobes_a(), 32'b11111_00);
    tick();
    idle_a();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("drain_%0d", i), strobes_a(), 32'b01111_11);
      chk($sformatf("drain_halted_%0d", i), {31'd0, ifa.halted}, 32'd0);
      ifa.halt_req = 1'b1;
      ifa.take_branch = 1'b1;
      tick();
      idle_a();
    end
    #1;
    chk("halt_strobes",  strobes_a(), 32'b00000_00);
    chk("halt_flag",     {31'd0, ifa.halted}, 32'd1);
    chk("halt_stallcnt", ifa.stall_cycles, 32'd3);
    chk("halt_flushcnt", ifa.flush_count, 32'd2);
    ifa.resume = 1'b1;
    tick();
    idle_a();
    #1;
    chk("resume_halted",  {31'd0, ifa.halted}, 32'd0);
    chk("resume_strobes", strobes_a(), 32'b11111_00);

    // Halt with a 5-cycle memory stall after the first drain cycle
    ifa.halt_req = 1'b1;
    tick();
    idle_a();
    tick();
    ifa.dmem_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("drain_busy_%0d", i), strobes_a(), 32'b00000_00);
      chk($sformatf("drain_busy_halted_%0d", i), {31'd0, ifa.halted}, 32'd0);
      tick();
    end
    idle_a();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("drain_post_%0d", i), strobes_a(), 32'b01111_11);
      chk($sformatf("drain_post_halted_%0d", i), {31'd0, ifa.halted}, 32'd0);
      tick();
    end
    #1;
    chk("busy_drain_halted",  {31'd0, ifa.halted}, 32'd1);
    chk("busy_drain_err",     {31'd0, ifa.err_timeout}, 32'd0);
    chk("busy_drain_stallcnt", ifa.stall_cycles, 32'd3);
    ifa.resume = 1'b1;
    tick();
    idle_a();

    // Watchdog: MEM_TIMEOUT=4, busy held from cycle 0
    ifb.dmem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      chk($sformatf("wd_pending_%0d", i), {30'd0, ifb.halted, ifb.err_timeout}, 32'd0);
    end
    tick();
    #1;
    chk("wd_halted",   {31'd0, ifb.halted}, 32'd1);
    chk("wd_err",      {31'd0, ifb.err_timeout}, 32'd1);
    chk("wd_stallcnt", ifb.stall_cycles, 32'd5);
    ifb.dmem_busy = 1'b0;
    ifb.resume    = 1'b1;
    tick();
    tick();
    #1;
    chk("wd_resume_ignored", {31'd0, ifb.halted}, 32'd1);
    chk("wd_err_sticky",     {31'd0, ifb.err_timeout}, 32'd1);
    ifb.resume = 1'b0;
    reset = 1'b1;
    #1;
    chk("wd_reset_halted", {31'd0, ifb.halted}, 32'd0);
    chk("wd_reset_err",    {31'd0, ifb.err_timeout}, 32'd0);
    chk("wd_reset_stall",  ifb.stall_cycles, 32'd0);
    chk("a_reset_flush",   ifa.flush_count, 32'd0);
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
